pgm_chk: RTL and testbench

Receive-side counterpart of the packet generator. Sits at the far end of the test path, on the 134-bit flit bus. Forwards every flit unchanged with one cycle of latency. While forwarding, it recognises generator test packets, takes the sequence number and transmit timestamp out of their tag flit, and accumulates loss, reorder, latency and throughput statistics. Software reads those statistics through the standard control-packet chain (MID `LMID`).

---
 rtl/pgm_chk.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_pgm_chk.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgm_chk.sv
`default_nettype none
// ============================================================================
// Module   : pgm_chk
// Purpose  : Receive-side packet checker. Forwards every data flit, PHV and
//            valid flag unchanged with one cycle of latency. While forwarding,
//            it recognises generator test packets, extracts the sequence
//            number and transmit timestamp from their tag flit, and keeps
//            loss / reorder / latency / throughput statistics that software
//            reads through the control-packet chain (MID = LMID).
// Ports    : clk, rst_n (sync, active-low)
//            in_chk_*  / out_chk_*  : data flit, valid, PHV in/out (+alf copies)
//            cin_chk_* / cout_chk_* : control flit chain in/out (+ready copy)
//            in_chk_time            : free-running timestamp shared with the
//                                     generator
// Config   : `define PGM_CHK_LAT_EN builds the latency statistics
//            (lat_min / lat_max / lat_sum); without it addresses 0x7-0xA
//            read 32'hFFFFFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module pgm_chk #(
    parameter             PLATFORM = "Xilinx",
    parameter logic [7:0] LMID     = 8'd63,
    parameter logic [7:0] NMID     = 8'd5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [133:0]  in_chk_data,
    input  logic          in_chk_data_wr,
    input  logic          in_chk_valid,
    input  logic          in_chk_valid_wr,
    input  logic [1023:0] in_chk_phv,
    input  logic          in_chk_phv_wr,
    output logic          out_chk_alf,
    output logic          out_chk_phv_alf,
    output logic [133:0]  out_chk_data,
    output logic          out_chk_data_wr,
    output logic          out_chk_valid,
    output logic          out_chk_valid_wr,
    output logic [1023:0] out_chk_phv,
    output logic          out_chk_phv_wr,
    input  logic          in_chk_alf,
    input  logic          in_chk_phv_alf,
    input  logic [133:0]  cin_chk_data,
    input  logic          cin_chk_data_wr,
    output logic          cout_chk_ready,
    output logic [133:0]  cout_chk_data,
    output logic          cout_chk_data_wr,
    input  logic          cin_chk_ready,
    input  logic [31:0]   in_chk_time
);

    localparam logic [1:0] c_flit_head = 2'b01;
    localparam logic [1:0] c_flit_body = 2'b11;
    localparam logic [1:0] c_flit_tail = 2'b10;
    localparam logic       c_is_xilinx = (PLATFORM == "Xilinx");

    typedef enum logic [0:0] {
        IDLE_S = 1'b0,
        BODY_S = 1'b1
    } state_t;

    state_t       r_state, w_next_state;
    logic [3:0]   r_flit_idx;
    logic         w_is_head, w_is_body, w_is_tail;
    logic         w_err_inc, w_pkt_done, w_tag_hit, w_idx_clr, w_idx_inc;
    logic [4:0]   w_add_bytes;

    logic         r_eval_pend, r_first, r_soft_rst, r_cwr_drop;
    logic [63:0]  r_seq, r_exp_seq, r_rx_pkt_cnt, r_rx_byte_cnt;
    logic [31:0]  r_test_pkt_cnt, r_lost_cnt, r_reorder_cnt, r_err_cnt;
    logic [63:0]  w_seq_gap;
    logic [64:0]  w_lost_sum;
    logic [31:0]  w_lost_next, w_rdata;
    logic         w_c_mine, w_c_wr, w_c_rd;
    logic         w_unused_ok;

    // ---------------------------------------------------------------- data path
    assign out_chk_alf     = in_chk_alf;
    assign out_chk_phv_alf = in_chk_phv_alf;
    assign cout_chk_ready  = cin_chk_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_chk_data     <= '0;
            out_chk_data_wr  <= 1'b0;
            out_chk_valid    <= 1'b0;
            out_chk_valid_wr <= 1'b0;
            out_chk_phv      <= '0;
            out_chk_phv_wr   <= 1'b0;
        end else begin
            out_chk_data     <= in_chk_data;
            out_chk_data_wr  <= in_chk_data_wr;
            out_chk_valid    <= in_chk_valid;
            out_chk_valid_wr <= in_chk_valid_wr;
            out_chk_phv      <= in_chk_phv;
            out_chk_phv_wr   <= in_chk_phv_wr;
        end
    end

    // ---------------------------------------------------------- framing FSM
    assign w_is_head = (in_chk_data[133:132] == c_flit_head);
    assign w_is_body = (in_chk_data[133:132] == c_flit_body);
    assign w_is_tail = (in_chk_data[133:132] == c_flit_tail);

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE_S;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_err_inc    = 1'b0;
        w_pkt_done   = 1'b0;
        w_tag_hit    = 1'b0;
        w_idx_clr    = 1'b0;
        w_idx_inc    = 1'b0;
        w_add_bytes  = 5'd0;
        if (in_chk_data_wr) begin
            case (r_state)
                IDLE_S: begin
                    if (w_is_head) begin
                        w_idx_clr    = 1'b1;
                        w_add_bytes  = 5'd16;
                        w_next_state = BODY_S;
                    end else if (w_is_body || w_is_tail) begin
                        w_err_inc = 1'b1;
                    end
                end
                BODY_S: begin
                    w_idx_inc = 1'b1;
                    if (w_is_head) begin
                        // Lost tail: count it, restart on this head.
                        w_err_inc   = 1'b1;
                        w_idx_clr   = 1'b1;
                        w_add_bytes = 5'd16;
                    end else if (w_is_body) begin
                        w_add_bytes = 5'd16;
                        // flit_idx holds the count of flits seen after the
                        // head, so the tag is the 7th flit of the packet.
                        w_tag_hit   = (r_flit_idx == 4'd5) &&
                                      (in_chk_data[31:0] == 32'hFFFF_FFFF);
                    end else if (w_is_tail) begin
                        w_pkt_done   = 1'b1;
                        w_add_bytes  = {1'b0, in_chk_data[131:128]};
                        w_next_state = IDLE_S;
                    end
                end
                default: w_next_state = IDLE_S;
            endcase
        end
    end

    // Saturates so very long packets cannot wrap back onto the tag position.
    always_ff @(posedge clk) begin
        if (!rst_n)                              r_flit_idx <= 4'd0;
        else if (w_idx_clr)                      r_flit_idx <= 4'd0;
        else if (w_idx_inc && r_flit_idx != 4'hF) r_flit_idx <= r_flit_idx + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_eval_pend <= 1'b0;
            r_seq       <= '0;
        end else begin
            r_eval_pend <= w_tag_hit;
            if (w_tag_hit) r_seq <= in_chk_data[127:64];
        end
    end

    // ----------------------------------------------------------- statistics
    assign w_seq_gap   = r_seq - r_exp_seq;
    assign w_lost_sum  = {33'd0, r_lost_cnt} + {1'b0, w_seq_gap};
    assign w_lost_next = (|w_lost_sum[64:32]) ? 32'hFFFF_FFFF : w_lost_sum[31:0];

    always_ff @(posedge clk) begin
        if (!rst_n || r_soft_rst) begin
            r_rx_pkt_cnt   <= '0;
            r_rx_byte_cnt  <= '0;
            r_err_cnt      <= '0;
            r_test_pkt_cnt <= '0;
            r_lost_cnt     <= '0;
            r_reorder_cnt  <= '0;
            r_exp_seq      <= '0;
            r_first        <= 1'b1;
        end else begin
            if (w_err_inc)  r_err_cnt    <= r_err_cnt + 32'd1;
            if (w_pkt_done) r_rx_pkt_cnt <= r_rx_pkt_cnt + 64'd1;
            r_rx_byte_cnt <= r_rx_byte_cnt + {59'd0, w_add_bytes};
            if (r_eval_pend) begin
                r_test_pkt_cnt <= r_test_pkt_cnt + 32'd1;
                if (r_first) begin
                    r_first   <= 1'b0;
                    r_exp_seq <= r_seq + 64'd1;
                end else if (r_seq == r_exp_seq) begin
                    r_exp_seq <= r_exp_seq + 64'd1;
                end else if (r_seq > r_exp_seq) begin
                    r_lost_cnt <= w_lost_next;
                    r_exp_seq  <= r_seq + 64'd1;
                end else begin
                    r_reorder_cnt <= r_reorder_cnt + 32'd1;
                end
            end
        end
    end

`ifdef PGM_CHK_LAT_EN
    logic [31:0] r_ts, r_lat_min, r_lat_max, w_lat;
    logic [63:0] r_lat_sum;

    // Modulo-2^32 difference tolerates timestamp wrap between tx and rx.
    assign w_lat = in_chk_time - r_ts;

    always_ff @(posedge clk) begin
        if (!rst_n)         r_ts <= '0;
        else if (w_tag_hit) r_ts <= in_chk_data[63:32];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || r_soft_rst) begin
            r_lat_min <= 32'hFFFF_FFFF;
            r_lat_max <= '0;
            r_lat_sum <= '0;
        end else if (r_eval_pend) begin
            if (w_lat < r_lat_min) r_lat_min <= w_lat;
            if (w_lat > r_lat_max) r_lat_max <= w_lat;
            r_lat_sum <= r_lat_sum + {32'd0, w_lat};
        end
    end

    assign w_unused_ok = ^{NMID, c_is_xilinx};
`else
    assign w_unused_ok = ^{NMID, c_is_xilinx, in_chk_time};
`endif

    // --------------------------------------------------------- control path
    assign w_c_mine = (cin_chk_data[133:132] == c_flit_head) &&
                      (cin_chk_data[103:96] == LMID);
    assign w_c_wr   = w_c_mine && (cin_chk_data[126:124] == 3'b010);
    assign w_c_rd   = w_c_mine && (cin_chk_data[126:124] == 3'b001);

    always_comb begin
        w_rdata = 32'hFFFF_FFFF;
        case (cin_chk_data[95:64])
            32'h0:   w_rdata = {31'd0, r_soft_rst};
            32'h1:   w_rdata = r_rx_pkt_cnt[31:0];
            32'h2:   w_rdata = r_rx_pkt_cnt[63:32];
            32'h3:   w_rdata = r_test_pkt_cnt;
            32'h4:   w_rdata = r_lost_cnt;
            32'h5:   w_rdata = r_reorder_cnt;
            32'h6:   w_rdata = r_err_cnt;
`ifdef PGM_CHK_LAT_EN
            32'h7:   w_rdata = r_lat_min;
            32'h8:   w_rdata = r_lat_max;
            32'h9:   w_rdata = r_lat_sum[31:0];
            32'hA:   w_rdata = r_lat_sum[63:32];
`endif
            32'hB:   w_rdata = r_rx_byte_cnt[31:0];
            32'hC:   w_rdata = r_rx_byte_cnt[63:32];
            default: w_rdata = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cout_chk_data    <= '0;
            cout_chk_data_wr <= 1'b0;
            r_cwr_drop       <= 1'b0;
            r_soft_rst       <= 1'b0;
        end else if (cin_chk_data_wr) begin
            if (r_cwr_drop) begin
                // Remainder of our write packet is swallowed up to its tail.
                cout_chk_data_wr <= 1'b0;
                if (cin_chk_data[133:132] == c_flit_tail) r_cwr_drop <= 1'b0;
            end else if (w_c_wr) begin
                cout_chk_data_wr <= 1'b0;
                r_cwr_drop       <= 1'b1;
                if (cin_chk_data[95:64] == 32'h0) r_soft_rst <= cin_chk_data[0];
            end else if (w_c_rd) begin
                cout_chk_data_wr <= 1'b1;
                cout_chk_data    <= {cin_chk_data[133:128], 4'b1011,
                                     cin_chk_data[123:112], cin_chk_data[103:96],
                                     cin_chk_data[111:104], cin_chk_data[95:32],
                                     w_rdata};
            end else begin
                cout_chk_data_wr <= 1'b1;
                cout_chk_data    <= cin_chk_data;
            end
        end else begin
            cout_chk_data_wr <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pgm_chk.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pgm_chk
// Purpose  : Self-checking bench for pgm_chk. Every driven cycle of the data
//            bus and every control flit that must reappear is queued with its
//            expected value and compared when the DUT produces it; statistics
//            are read back through control reads with hand-derived values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pgm_chk;

    localparam logic [7:0] c_lmid = 8'd63;
    localparam logic [7:0] c_nmid = 8'd5;
`ifdef PGM_CHK_LAT_EN
    localparam bit c_lat = 1'b1;
`else
    localparam bit c_lat = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [133:0]  in_chk_data;
    logic          in_chk_data_wr, in_chk_valid, in_chk_valid_wr, in_chk_phv_wr;
    logic [1023:0] in_chk_phv;
    logic          out_chk_alf, out_chk_phv_alf;
    logic [133:0]  out_chk_data;
    logic          out_chk_data_wr, out_chk_valid, out_chk_valid_wr, out_chk_phv_wr;
    logic [1023:0] out_chk_phv;
    logic          in_chk_alf, in_chk_phv_alf;
    logic [133:0]  cin_chk_data;
    logic          cin_chk_data_wr;
    logic          cout_chk_ready;
    logic [133:0]  cout_chk_data;
    logic          cout_chk_data_wr;
    logic          cin_chk_ready;
    logic [31:0]   in_chk_time;

    always #5 clk = ~clk;

    pgm_chk #(.PLATFORM("Xilinx"), .LMID(c_lmid), .NMID(c_nmid)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_chk_data(in_chk_data), .in_chk_data_wr(in_chk_data_wr),
        .in_chk_valid(in_chk_valid), .in_chk_valid_wr(in_chk_valid_wr),
        .in_chk_phv(in_chk_phv), .in_chk_phv_wr(in_chk_phv_wr),
        .out_chk_alf(out_chk_alf), .out_chk_phv_alf(out_chk_phv_alf),
        .out_chk_data(out_chk_data), .out_chk_data_wr(out_chk_data_wr),
        .out_chk_valid(out_chk_valid), .out_chk_valid_wr(out_chk_valid_wr),
        .out_chk_phv(out_chk_phv), .out_chk_phv_wr(out_chk_phv_wr),
        .in_chk_alf(in_chk_alf), .in_chk_phv_alf(in_chk_phv_alf),
        .cin_chk_data(cin_chk_data), .cin_chk_data_wr(cin_chk_data_wr),
        .cout_chk_ready(cout_chk_ready), .cout_chk_data(cout_chk_data),
        .cout_chk_data_wr(cout_chk_data_wr), .cin_chk_ready(cin_chk_ready),
        .in_chk_time(in_chk_time)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    logic [31:0] tcount = 32'hFFFF_FFF0;   // starts near wrap on purpose

    typedef struct packed {
        logic [133:0]  data;
        logic          data_wr;
        logic          valid;
        logic          valid_wr;
        logic          phv_wr;
        logic [1023:0] phv;
    } fwd_t;

    fwd_t         dq[$];      // expected forwarded data-side bundle, next cycle
    logic [133:0] cq_d[$];    // expected control output flits
    int           cq_c[$];    // cycle on which each must appear

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard side: compare what was queued, then queue this cycle's inputs.
    always @(negedge clk) begin
        fwd_t e;
        if (dq.size() > 0) begin
            e = dq.pop_front();
            check("fwd_bus",
                  {118'd0, out_chk_data, out_chk_data_wr, out_chk_valid, out_chk_valid_wr, out_chk_phv_wr},
                  {118'd0, e.data, e.data_wr, e.valid, e.valid_wr, e.phv_wr});
            for (int k = 0; k < 4; k++)
                check($sformatf("fwd_phv%0d", k), out_chk_phv[k*256 +: 256], e.phv[k*256 +: 256]);
        end
        if (rst_n) begin
            e.data = in_chk_data; e.data_wr = in_chk_data_wr; e.valid = in_chk_valid;
            e.valid_wr = in_chk_valid_wr; e.phv_wr = in_chk_phv_wr; e.phv = in_chk_phv;
        end else begin
            e = '0;
        end
        dq.push_back(e);

        if (cq_d.size() > 0 && cq_c[0] == cyc) begin
            check("ctl_wr", {255'd0, cout_chk_data_wr}, 256'd1);
            check("ctl_data", {122'd0, cout_chk_data}, {122'd0, cq_d[0]});
            void'(cq_d.pop_front());
            void'(cq_c.pop_front());
        end else begin
            check("ctl_idle", {255'd0, cout_chk_data_wr}, 256'd0);
        end
    end

    function automatic logic [133:0] rnd_flit();
        logic [159:0] r;
        for (int i = 0; i < 5; i++) r[i*32 +: 32] = $urandom;
        r[31] = 1'b0;     // never looks like a tag marker by accident
        return r[133:0];
    endfunction

    task automatic step(input logic dwr, input logic [133:0] d, input logic cwr, input logic [133:0] c);
        @(posedge clk); #1;
        in_chk_data_wr  = dwr;
        in_chk_data     = d;
        cin_chk_data_wr = cwr;
        cin_chk_data    = c;
        in_chk_valid    = 1'($urandom_range(1, 0));
        in_chk_valid_wr = 1'($urandom_range(1, 0));
        in_chk_phv_wr   = 1'($urandom_range(1, 0));
        for (int i = 0; i < 32; i++) in_chk_phv[i*32 +: 32] = $urandom;
        in_chk_time     = tcount;
        tcount          = tcount + 32'd1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
    endtask

    // Tag (when is_test) is the 7th flit; eval sees the next cycle's time.
    task automatic send_pkt(input int n, input logic is_test, input logic [63:0] seq,
                            input logic [31:0] lat, input logic [3:0] tail_bytes);
        logic [133:0] f;
        for (int i = 0; i < n; i++) begin
            f = rnd_flit();
            if (i == 0) f[133:132] = 2'b01;
            else if (i == n - 1) begin f[133:132] = 2'b10; f[131:128] = tail_bytes; end
            else f[133:132] = 2'b11;
            if (is_test && i == 6) begin
                f[127:64] = seq;
                f[63:32]  = tcount + 32'd1 - lat;
                f[31:0]   = 32'hFFFF_FFFF;
            end
            step(1'b1, f, 1'b0, '0);
        end
    endtask

    task automatic cq_push(input logic [133:0] f);
        cq_d.push_back(f);
        cq_c.push_back(cyc + 1);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] expv);
        logic [133:0] h, t;
        h = rnd_flit();
        h[133:132] = 2'b01; h[126:124] = 3'b001; h[103:96] = c_lmid; h[95:64] = addr;
        step(1'b0, '0, 1'b1, h);
        cq_push({h[133:128], 4'b1011, h[123:112], h[103:96], h[111:104], h[95:32], expv});
        t = rnd_flit(); t[133:132] = 2'b10;
        step(1'b0, '0, 1'b1, t);
        cq_push(t);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] val);
        logic [133:0] h, t;
        h = rnd_flit();
        h[133:132] = 2'b01; h[126:124] = 3'b010; h[103:96] = c_lmid;
        h[95:64] = addr; h[31:0] = val;
        step(1'b0, '0, 1'b1, h);
        t = rnd_flit(); t[133:132] = 2'b10;
        step(1'b0, '0, 1'b1, t);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [133:0] f;
        rst_n = 1'b0;
        in_chk_data = '0; in_chk_data_wr = 1'b0; in_chk_valid = 1'b0;
        in_chk_valid_wr = 1'b0; in_chk_phv = '0; in_chk_phv_wr = 1'b0;
        in_chk_alf = 1'b0; in_chk_phv_alf = 1'b0; cin_chk_ready = 1'b0;
        cin_chk_data = '0; cin_chk_data_wr = 1'b0; in_chk_time = '0;
        idle(3);
        rst_n = 1'b1;
        idle(2);

        // Reset values
        rd(32'h0, 32'd0);
        rd(32'h1, 32'd0);
        rd(32'h6, 32'd0);
        rd(32'h7, 32'hFFFF_FFFF);

        // Transparency: 3 back-to-back 8-flit packets, 120 bytes each
        for (int p = 0; p < 3; p++) send_pkt(8, 1'b0, 64'd0, 32'd0, 4'd8);
        idle(3);
        rd(32'h1, 32'd3);
        rd(32'h2, 32'd0);
        rd(32'h6, 32'd0);
        rd(32'hB, 32'd360);

        // Soft reset holds statistics while traffic still flows
        wr(32'h0, 32'd1);
        rd(32'h0, 32'd1);
        send_pkt(8, 1'b0, 64'd0, 32'd0, 4'd8);
        idle(3);
        rd(32'h1, 32'd0);
        rd(32'hB, 32'd0);
        wr(32'h0, 32'd0);
        rd(32'h0, 32'd0);
        rd(32'h1, 32'd0);

        // In-order sequence with latencies 40, 50, 45
        send_pkt(8, 1'b1, 64'd10, 32'd40, 4'd8);
        send_pkt(8, 1'b1, 64'd11, 32'd50, 4'd8);
        send_pkt(8, 1'b1, 64'd12, 32'd45, 4'd8);
        idle(3);
        rd(32'h3, 32'd3);
        rd(32'h4, 32'd0);
        rd(32'h5, 32'd0);
        rd(32'h1, 32'd3);
        rd(32'h7, c_lat ? 32'd40  : 32'hFFFF_FFFF);
        rd(32'h8, c_lat ? 32'd50  : 32'hFFFF_FFFF);
        rd(32'h9, c_lat ? 32'd135 : 32'hFFFF_FFFF);
        rd(32'hA, c_lat ? 32'd0   : 32'hFFFF_FFFF);

        // Loss and reorder: 0,1,5,3 then 6 proves next expected is 6
        wr(32'h0, 32'd1);
        wr(32'h0, 32'd0);
        send_pkt(8, 1'b1, 64'd0, 32'd10, 4'd8);
        send_pkt(8, 1'b1, 64'd1, 32'd10, 4'd8);
        send_pkt(8, 1'b1, 64'd5, 32'd10, 4'd8);
        send_pkt(8, 1'b1, 64'd3, 32'd10, 4'd8);
        send_pkt(8, 1'b1, 64'd6, 32'd10, 4'd8);
        idle(3);
        rd(32'h4, 32'd3);
        rd(32'h5, 32'd1);
        rd(32'h3, 32'd5);
        // Gap beyond 32 bits saturates the loss counter
        send_pkt(8, 1'b1, 64'h2_0000_0006, 32'd10, 4'd8);
        idle(3);
        rd(32'h4, 32'hFFFF_FFFF);
        rd(32'h3, 32'd6);

        // Framing errors: tail in idle, then head inside a packet
        wr(32'h0, 32'd1);
        wr(32'h0, 32'd0);
        f = rnd_flit(); f[133:132] = 2'b10;
        step(1'b1, f, 1'b0, '0);
        f = rnd_flit(); f[133:132] = 2'b01;
        step(1'b1, f, 1'b0, '0);
        f = rnd_flit(); f[133:132] = 2'b11;
        step(1'b1, f, 1'b0, '0);
        send_pkt(8, 1'b0, 64'd0, 32'd0, 4'd8);
        idle(3);
        rd(32'h6, 32'd2);
        rd(32'h1, 32'd1);
        send_pkt(8, 1'b0, 64'd0, 32'd0, 4'd8);
        idle(3);
        rd(32'h1, 32'd2);
        rd(32'h6, 32'd2);

        // Byte count of one 64-byte packet, unmapped addresses
        wr(32'h0, 32'd1);
        wr(32'h0, 32'd0);
        send_pkt(5, 1'b0, 64'd0, 32'd0, 4'd0);
        idle(3);
        rd(32'hB, 32'd64);
        rd(32'hC, 32'd0);
        rd(32'h7F, 32'hFFFF_FFFF);
        rd(32'hD, 32'hFFFF_FFFF);

        // Synchronous reset during flit 3 of a packet
        for (int i = 0; i < 4; i++) begin
            f = rnd_flit();
            f[133:132] = (i == 0) ? 2'b01 : 2'b11;
            step(1'b1, f, 1'b0, '0);
        end
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(2);
        rd(32'h1, 32'd0);
        rd(32'hB, 32'd0);
        send_pkt(8, 1'b0, 64'd0, 32'd0, 4'd8);
        idle(3);
        rd(32'h1, 32'd1);
        rd(32'h6, 32'd0);

        // Foreign-MID read and own-MID unknown opcode pass through untouched
        f = rnd_flit(); f[133:132] = 2'b01; f[126:124] = 3'b001; f[103:96] = c_nmid;
        step(1'b0, '0, 1'b1, f); cq_push(f);
        f = rnd_flit(); f[133:132] = 2'b01; f[126:124] = 3'b011; f[103:96] = c_lmid;
        step(1'b0, '0, 1'b1, f); cq_push(f);
        f = rnd_flit(); f[133:132] = 2'b10;
        step(1'b0, '0, 1'b1, f); cq_push(f);

        // Combinational almost-full / ready copies
        in_chk_alf = 1'b1; in_chk_phv_alf = 1'b0; cin_chk_ready = 1'b1;
        #1;
        check("alf_hi", {255'd0, out_chk_alf}, 256'd1);
        check("phv_alf_lo", {255'd0, out_chk_phv_alf}, 256'd0);
        check("ready_hi", {255'd0, cout_chk_ready}, 256'd1);
        in_chk_alf = 1'b0; in_chk_phv_alf = 1'b1; cin_chk_ready = 1'b0;
        #1;
        check("alf_lo", {255'd0, out_chk_alf}, 256'd0);
        check("phv_alf_hi", {255'd0, out_chk_phv_alf}, 256'd1);
        check("ready_lo", {255'd0, cout_chk_ready}, 256'd0);

        idle(4);
        check("ctl_queue_drained", 256'(cq_d.size()), 256'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
